bos_afe_model: RTL and testbench
================================

# bos_afe_model

Synthesizable emulator of the SBIS BOS analog front end's digital behaviour, for loopback testing of the functional-test path without silicon. It consumes the timing strobes the test generator drives toward BOS (clk_fpga, shp_fpga, shd_fpga, clpob_fpga, pblk_fpga, vd_fpga) plus the digitized video word (the DAC code looped back). It performs correlated double sampling, black-level clamp and pipeline delay, then returns q_fpga/dataclk_fpga exactly as the BOS parallel output would.

## Interface
- DATA_IN_W, 14, width of looped-back video word
- Q_W, 12, output code width
- PIPE_PIX, 4, pipeline latency in pixels (≥1)
- CLAMP_SHIFT, 3, clamp loop gain = 2^-CLAMP_SHIFT
- PEDESTAL, 64, black output code added after clamp
- sys_clk  in  1  single clock; all inputs synchronous to it
- n_rst  in  1  asynchronous, active-low reset
- adc_in  in  DATA_IN_W  looped-back video level (unsigned)
- shp_fpga  in  1  reset-level sample strobe, active low, sample on rise
- shd_fpga  in  1  video-level sample strobe, active low, sample on rise
- clpob_fpga  in  1  optical-black clamp enable
- pblk_fpga  in  1  blanking; forces output code 0
- vd_fpga  in  1  frame sync; rise clears pixel_cnt
- err_clr  in  1  clears sticky error flags
- q_fpga  out  Q_W  output code
- dataclk_fpga  out  1  output data strobe
- pixel_cnt  out  16  pixels pushed since last vd rise
- err_seq  out  1  sticky: strobe sequence violated

## Operation
- Edge detect: prev registers for shp/shd/vd, reset to 1; rise = cur & !prev, fall = !cur & prev. No synchronizers.
- FSM (reset IDLE):
  - IDLE: shp fall → RST_SMP.
  - RST_SMP: shp rise → latch reset_s = adc_in, → VID_WAIT.
  - VID_WAIT: shd fall → VID_SMP; shp fall → err_seq=1, → RST_SMP.
  - VID_SMP: shd rise → latch video_s = adc_in, issue push, → IDLE; shp fall → err_seq=1, → RST_SMP.
- Any other edge, including shd rise in IDLE/RST_SMP, is ignored with no push; err_seq unaffected.
- Arithmetic, one cycle after push issue:
  - cds = video_s − reset_s, signed 15b.
  - offset = offset_acc >>> CLAMP_SHIFT; offset_acc signed 18b, reset 0.
  - corr = (cds − offset) >>> 2 + PEDESTAL, saturated to [0, 2^Q_W−1]; 0 if pblk_fpga is high on the push cycle.
  - If clpob_fpga is high on the push-issue cycle: offset_acc += cds − offset, saturating at 18b. Correction uses the pre-update offset.
- Pipeline: PIPE_PIX stages of Q_W, reset 0; each push shifts corr into stage 0. q_fpga = stage[PIPE_PIX−1].
- pixel_cnt increments per push, wraps at 65535→0. vd rise clears it; vd rise coincident with a push sets it to 1.
- err_clr clears err_seq; a simultaneous set wins.

## Timing
- Edge detected in cycle T when the input changed at end of T−1. Latch at end of T, stage registers update at end of T+1. q_fpga is new from T+2.
- dataclk_fpga rises at T+3 and stays high exactly 2 cycles. q_fpga is stable ≥1 cycle before the rise and through the high phase.
- Minimum supported pixel period: 8 sys_clk cycles between shd rises. Shorter periods: a new push restarts the dataclk pulse; no other guarantees.
- Reset values: q_fpga=0, dataclk_fpga=0, pixel_cnt=0, err_seq=0, FSM IDLE, offset_acc=0.
- Reset mid-pixel: all state cleared asynchronously. The first push after release requires a full shp fall/rise, shd fall/rise sequence.

## Test plan
- PIPE_PIX=1, clpob=0: reset level 1000, video 5000 → q_fpga=1064 at T+2, dataclk high T+3..T+4, pixel_cnt=1.
- Saturation: reset 3000 / video 1000 → q=0. Reset 0 / video 16383 → q=4095.
- Clamp: clpob=1, cds=800 constant. Pixel 1 q=264, offset_acc→800. Pixel 2 q=239 (offset 100). Over 64 pixels q converges to 64 ±1.
- PIPE_PIX=4: feed cds 400, 800, 1200, 1600, 2000 → q sequence 0, 0, 0, 164, 264.
- Sequence errors:
  - Two shp pulses without shd → err_seq=1, no push. The next valid pixel is correct.
  - err_clr → err_seq=0. err_clr coincident with a new violation → err_seq stays 1.
- Reset mid-pixel: assert n_rst between shp rise and shd rise. After release, a lone shd pulse gives no push (q=0, pixel_cnt=0). vd rise with pblk=1 → pixel_cnt restarts, q=0 for blanked pixels.

Source files
------------

// File: rtl/bos_afe_model_if.sv
// ============================================================================
// bos_afe_model_if : strobe, video and output bundle of the BOS AFE emulator
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bos_afe_model_if #(
  parameter int DATA_IN_W = 14,
  parameter int Q_W       = 12
);
  logic [DATA_IN_W-1:0] adc_in;
  logic                 shp_fpga;
  logic                 shd_fpga;
  logic                 clpob_fpga;
  logic                 pblk_fpga;
  logic                 vd_fpga;
  logic                 err_clr;
  logic [Q_W-1:0]       q_fpga;
  logic                 dataclk_fpga;
  logic [15:0]          pixel_cnt;
  logic                 err_seq;

  modport master (
    output adc_in, shp_fpga, shd_fpga, clpob_fpga, pblk_fpga, vd_fpga, err_clr,
    input  q_fpga, dataclk_fpga, pixel_cnt, err_seq
  );

  modport slave (
    input  adc_in, shp_fpga, shd_fpga, clpob_fpga, pblk_fpga, vd_fpga, err_clr,
    output q_fpga, dataclk_fpga, pixel_cnt, err_seq
  );
endinterface

`default_nettype wire

// File: rtl/bos_afe_model.sv
// ============================================================================
// bos_afe_model : CDS, black-level clamp and pixel pipeline of the BOS AFE
// Revision: 1.0
// ============================================================================
`default_nettype none

module bos_afe_model #(
  parameter int DATA_IN_W   = 14,
  parameter int Q_W         = 12,
  parameter int PIPE_PIX    = 4,
  parameter int CLAMP_SHIFT = 3,
  parameter int PEDESTAL    = 64
) (
  input  logic            sys_clk,
  input  logic            n_rst,
  bos_afe_model_if.slave  bus
);

  localparam int CDS_W = DATA_IN_W + 1;
  localparam int ACC_W = 18;
  localparam int EXT_W = ACC_W + 2;

  localparam logic signed [EXT_W-1:0] C_PEDESTAL = EXT_W'(PEDESTAL);
  localparam logic signed [EXT_W-1:0] C_Q_MAX    = EXT_W'((1 << Q_W) - 1);
  localparam logic signed [EXT_W-1:0] C_ACC_MAX  = EXT_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] C_ACC_MIN  = -EXT_W'(1 << (ACC_W - 1));

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RST_SMP  = 2'd1,
    S_VID_WAIT = 2'd2,
    S_VID_SMP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    shp_prev_q, shd_prev_q, vd_prev_q;
  logic [DATA_IN_W-1:0]    reset_s_q, video_s_q;
  logic                    clpob_s_q, pblk_s_q;
  logic                    push_q, push2_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [PIPE_PIX-1:0][Q_W-1:0] pipe_q;
  logic [15:0]             pixel_cnt_q, pixel_cnt_d;
  logic                    err_q, err_d;
  logic [1:0]              dclk_cnt_q;

  logic w_shp_fall, w_shp_rise, w_shd_fall, w_shd_rise, w_vd_rise;
  logic w_latch_rst, w_push, w_seq_err;

  assign w_shp_fall = !bus.shp_fpga &&  shp_prev_q;
  assign w_shp_rise =  bus.shp_fpga && !shp_prev_q;
  assign w_shd_fall = !bus.shd_fpga &&  shd_prev_q;
  assign w_shd_rise =  bus.shd_fpga && !shd_prev_q;
  assign w_vd_rise  =  bus.vd_fpga  && !vd_prev_q;

  // A fresh shp fall while a reset sample is pending is the sequence violation.
  always_comb begin
    state_d     = state_q;
    w_latch_rst = 1'b0;
    w_push      = 1'b0;
    w_seq_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_shp_fall) state_d = S_RST_SMP;
      end
      S_RST_SMP: begin
        if (w_shp_rise) begin
          w_latch_rst = 1'b1;
          state_d     = S_VID_WAIT;
        end
      end
      S_VID_WAIT: begin
        if (w_shp_fall) begin
          w_seq_err = 1'b1;
          state_d   = S_RST_SMP;
        end else if (w_shd_fall) begin
          state_d = S_VID_SMP;
        end
      end
      S_VID_SMP: begin
        if (w_shp_fall) begin
          w_seq_err = 1'b1;
          state_d   = S_RST_SMP;
        end else if (w_shd_rise) begin
          w_push  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic signed [CDS_W-1:0] w_cds;
  logic signed [ACC_W-1:0] w_offset;
  logic signed [ACC_W:0]   w_diff, w_scaled;
  logic signed [EXT_W-1:0] w_corr_full, w_acc_sum;
  logic [Q_W-1:0]          w_corr;
  logic signed [ACC_W-1:0] w_acc_next;

  assign w_cds    = $signed({1'b0, video_s_q}) - $signed({1'b0, reset_s_q});
  assign w_offset = acc_q >>> CLAMP_SHIFT;
  assign w_diff   = $signed({{(ACC_W + 1 - CDS_W){w_cds[CDS_W-1]}}, w_cds})
                  - $signed({w_offset[ACC_W-1], w_offset});
  assign w_scaled = w_diff >>> 2;
  assign w_corr_full = $signed({w_scaled[ACC_W], w_scaled}) + C_PEDESTAL;
  assign w_acc_sum   = $signed({{2{acc_q[ACC_W-1]}}, acc_q})
                     + $signed({w_diff[ACC_W], w_diff});

  always_comb begin
    w_corr = '0;
    if (pblk_s_q || w_corr_full[EXT_W-1]) w_corr = '0;
    else if (w_corr_full > C_Q_MAX)       w_corr = C_Q_MAX[Q_W-1:0];
    else                                  w_corr = w_corr_full[Q_W-1:0];
  end

  always_comb begin
    w_acc_next = w_acc_sum[ACC_W-1:0];
    if (w_acc_sum > C_ACC_MAX)      w_acc_next = C_ACC_MAX[ACC_W-1:0];
    else if (w_acc_sum < C_ACC_MIN) w_acc_next = C_ACC_MIN[ACC_W-1:0];
  end

  always_comb begin
    pixel_cnt_d = pixel_cnt_q;
    if (w_vd_rise)   pixel_cnt_d = w_push ? 16'd1 : 16'd0;
    else if (w_push) pixel_cnt_d = pixel_cnt_q + 16'd1;
    err_d = err_q;
    if (w_seq_err)        err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      shp_prev_q  <= 1'b1;
      shd_prev_q  <= 1'b1;
      vd_prev_q   <= 1'b1;
      reset_s_q   <= '0;
      video_s_q   <= '0;
      clpob_s_q   <= 1'b0;
      pblk_s_q    <= 1'b0;
      push_q      <= 1'b0;
      push2_q     <= 1'b0;
      acc_q       <= '0;
      pipe_q      <= '0;
      pixel_cnt_q <= '0;
      err_q       <= 1'b0;
      dclk_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      shp_prev_q  <= bus.shp_fpga;
      shd_prev_q  <= bus.shd_fpga;
      vd_prev_q   <= bus.vd_fpga;
      push_q      <= w_push;
      push2_q     <= push_q;
      pixel_cnt_q <= pixel_cnt_d;
      err_q       <= err_d;
      if (w_latch_rst) reset_s_q <= bus.adc_in;
      if (w_push) begin
        video_s_q <= bus.adc_in;
        clpob_s_q <= bus.clpob_fpga;
        pblk_s_q  <= bus.pblk_fpga;
      end
      // Correction above uses acc_q before this update takes effect.
      if (push_q && clpob_s_q) acc_q <= w_acc_next;
      if (push_q) begin
        pipe_q[0] <= w_corr;
        for (int i = 1; i < PIPE_PIX; i++) pipe_q[i] <= pipe_q[i-1];
      end
      if (push2_q)                 dclk_cnt_q <= 2'd2;
      else if (dclk_cnt_q != 2'd0) dclk_cnt_q <= dclk_cnt_q - 2'd1;
    end
  end

  assign bus.q_fpga       = pipe_q[PIPE_PIX-1];
  assign bus.dataclk_fpga = (dclk_cnt_q != 2'd0);
  assign bus.pixel_cnt    = pixel_cnt_q;
  assign bus.err_seq      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bos_afe_model.sv
// ============================================================================
// tb_bos_afe_model : directed and randomized checks of bos_afe_model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bos_afe_model;
  localparam int PIPE = 4;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  bos_afe_model_if #(.DATA_IN_W(14), .Q_W(12)) bus ();

  bos_afe_model #(
    .DATA_IN_W(14), .Q_W(12), .PIPE_PIX(PIPE), .CLAMP_SHIFT(3), .PEDESTAL(64)
  ) u_dut (
    .sys_clk(clk),
    .n_rst  (n_rst),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: clamp accumulator, output history, counters, error flag
  int acc_m, cnt_m, err_m, r_m;
  bit armed_m;
  int hist[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic samp();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    acc_m = 0; cnt_m = 0; err_m = 0; armed_m = 0; r_m = 0;
    hist = {};
    for (int i = 0; i < PIPE; i++) hist.push_back(0);
  endtask

  function automatic void model_push(input int v, input bit clp, input bit blk, input bit vdr);
    int cds, off, diff, c;
    cds  = v - r_m;
    off  = acc_m >>> 3;
    diff = cds - off;
    c    = (diff >>> 2) + 64;
    if (c < 0) c = 0;
    if (c > 4095) c = 4095;
    if (blk) c = 0;
    if (clp) begin
      acc_m = acc_m + diff;
      if (acc_m > 131071)  acc_m = 131071;
      if (acc_m < -131072) acc_m = -131072;
    end
    hist.push_back(c);
    void'(hist.pop_front());
    cnt_m = vdr ? 1 : (cnt_m + 1) % 65536;
    armed_m = 0;
  endfunction

  task automatic rst_half(input int r, input bit clr);
    step; bus.adc_in = 14'(r); bus.shp_fpga = 1'b0; bus.err_clr = clr;
    if (armed_m) err_m = 1;
    else if (clr) err_m = 0;
    step; bus.shp_fpga = 1'b1; bus.err_clr = 1'b0;
    armed_m = 1;
    r_m = r;
  endtask

  task automatic vid_half(input int v, input bit clp, input bit blk, input bit vdr);
    int old;
    step; bus.adc_in = 14'(v); bus.vd_fpga = 1'b0;
    step; bus.shd_fpga = 1'b0;
    step; bus.shd_fpga = 1'b1; bus.clpob_fpga = clp; bus.pblk_fpga = blk;
    if (vdr) bus.vd_fpga = 1'b1;
    old = hist[0];
    model_push(v, clp, blk, vdr);
    samp; check("q_hold", int'(bus.q_fpga), old);
    samp; check("q_new", int'(bus.q_fpga), hist[0]);
          check("dclk_pre", int'(bus.dataclk_fpga), 0);
          check("pixel_cnt", int'(bus.pixel_cnt), cnt_m);
    samp; check("dclk_hi1", int'(bus.dataclk_fpga), 1);
          check("q_stable", int'(bus.q_fpga), hist[0]);
    samp; check("dclk_hi2", int'(bus.dataclk_fpga), 1);
    samp; check("dclk_lo", int'(bus.dataclk_fpga), 0);
          check("err_seq", int'(bus.err_seq), err_m);
  endtask

  task automatic pixel(input int r, input int v, input bit clp, input bit blk, input bit vdr);
    rst_half(r, 1'b0);
    vid_half(v, clp, blk, vdr);
  endtask

  task automatic do_reset();
    step; n_rst = 1'b0;
    samp;
    check("rst_q", int'(bus.q_fpga), 0);
    check("rst_dclk", int'(bus.dataclk_fpga), 0);
    check("rst_pcnt", int'(bus.pixel_cnt), 0);
    check("rst_err", int'(bus.err_seq), 0);
    step; n_rst = 1'b1;
    model_reset();
  endtask

  task automatic lone_shd();
    step; bus.shd_fpga = 1'b0;
    step; bus.shd_fpga = 1'b1;
    repeat (5) samp;
    check("lone_pcnt", int'(bus.pixel_cnt), cnt_m);
    check("lone_q", int'(bus.q_fpga), hist[0]);
    check("lone_dclk", int'(bus.dataclk_fpga), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    bus.adc_in = '0; bus.shp_fpga = 1'b1; bus.shd_fpga = 1'b1;
    bus.clpob_fpga = 1'b0; bus.pblk_fpga = 1'b0; bus.vd_fpga = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    repeat (2) step;
    do_reset();

    // Pipeline fill: cds 400..2000
    for (int k = 1; k <= 5; k++) begin
      pixel(1000, 1000 + 400 * k, 1'b0, 1'b0, 1'b0);
      if (k == 4) check("pipe_164", int'(bus.q_fpga), 164);
      if (k == 5) check("pipe_264", int'(bus.q_fpga), 264);
    end

    pixel(1000, 5000, 1'b0, 1'b0, 1'b0);
    repeat (3) pixel(2000, 2100, 1'b0, 1'b0, 1'b0);
    check("basic_1064", int'(bus.q_fpga), 1064);

    pixel(3000, 1000, 1'b0, 1'b0, 1'b0);
    pixel(0, 16383, 1'b0, 1'b0, 1'b0);
    repeat (2) pixel(2000, 2100, 1'b0, 1'b0, 1'b0);
    check("sat_low", int'(bus.q_fpga), 0);
    pixel(2000, 2100, 1'b0, 1'b0, 1'b0);
    check("sat_high", int'(bus.q_fpga), 4095);

    // Clamp loop from a cleared accumulator
    do_reset();
    repeat (68) pixel(2000, 2800, 1'b1, 1'b0, 1'b0);
    check("clamp_conv", int'(bus.q_fpga >= 12'd63 && bus.q_fpga <= 12'd65), 1);

    // Sequence violations and error clearing
    rst_half(111, 1'b0);
    rst_half(1000, 1'b0);
    samp;
    check("seqerr_set", int'(bus.err_seq), 1);
    check("seqerr_nopush", int'(bus.pixel_cnt), cnt_m);
    vid_half(1500, 1'b0, 1'b0, 1'b0);
    step; bus.err_clr = 1'b1;
    step; bus.err_clr = 1'b0; err_m = 0;
    samp; check("errclr", int'(bus.err_seq), 0);
    rst_half(500, 1'b0);
    rst_half(900, 1'b1);
    samp; check("errclr_set_wins", int'(bus.err_seq), 1);
    vid_half(3000, 1'b0, 1'b0, 1'b0);
    lone_shd();

    // Randomized traffic
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 9) == 0) rst_half(int'($urandom_range(0, 16383)), 1'b0);
      if ($urandom_range(0, 7) == 0) begin
        step; bus.err_clr = 1'b1;
        step; bus.err_clr = 1'b0; err_m = 0;
      end
      pixel(int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of a pixel
    rst_half(700, 1'b0);
    do_reset();
    lone_shd();
    pixel(1000, 9000, 1'b0, 1'b1, 1'b1);
    check("vd_restart", int'(bus.pixel_cnt), 1);
    repeat (4) pixel(1000, 9000, 1'b0, 1'b1, 1'b0);
    check("blank_q", int'(bus.q_fpga), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
